dft_peak_detector: RTL and testbench

//  Downstream stage of the DFT core: consumes the XK_RE/XK_IM/BLK_EXP/FD_OUT/DATA_VALID output

---
 rtl/dft_peak_detector.sv | 176 +++++++++++++++++
 tb/tb_dft_peak_detector.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dft_peak_detector.sv
// dft_peak_detector: finds the strongest |X[k]|^2 bin over 0..NFFT/2 of each DFT output frame.
// Define PEAK_DC_SKIP_EN to exclude bin 0 from the comparison (eligible range 1..NFFT/2).
module dft_peak_detector #(
    parameter int N    = 18,
    parameter int NFFT = 4,
    localparam int LOG2_NFFT = $clog2(NFFT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [N-1:0]  XK_RE,
    input  logic signed [N-1:0]  XK_IM,
    input  logic [3:0]           BLK_EXP,
    input  logic                 FD_OUT,
    input  logic                 DATA_VALID,
    output logic [LOG2_NFFT-1:0] PEAK_BIN,
    output logic [2*N:0]         PEAK_MAG,
    output logic [3:0]           PEAK_EXP,
    output logic                 PEAK_VALID,
    output logic                 FRAME_ERR
);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

    localparam logic [LOG2_NFFT-1:0] LAST_BIN = LOG2_NFFT'(NFFT - 1);
    localparam logic [LOG2_NFFT-1:0] HALF_BIN = LOG2_NFFT'(NFFT / 2);

`ifdef PEAK_DC_SKIP_EN
    localparam logic [LOG2_NFFT-1:0] DEF_BIN = LOG2_NFFT'(1);
    function automatic logic eligible(input logic [LOG2_NFFT-1:0] idx);
        return (idx != '0) && (idx <= HALF_BIN);
    endfunction
`else
    localparam logic [LOG2_NFFT-1:0] DEF_BIN = '0;
    function automatic logic eligible(input logic [LOG2_NFFT-1:0] idx);
        return idx <= HALF_BIN;
    endfunction
`endif

    // Full-precision square; the most negative input squares to 2^(2N-2), which still fits.
    function automatic logic [2*N-1:0] square(input logic signed [N-1:0] x);
        logic signed [2*N-1:0] xe;
        logic signed [2*N-1:0] p;
        xe = (2*N)'(x);
        p  = xe * xe;
        return $unsigned(p);
    endfunction

    state_t                 r_state;
    logic [LOG2_NFFT-1:0]   r_cnt;
    logic                   r_drain;
    logic [3:0]             r_exp;

    logic                   w_fd;
    logic                   w_take;
    logic                   w_last;
    logic [LOG2_NFFT-1:0]   w_idx;
    logic [3:0]             w_exp;

    logic                   r_vld_p1, r_first_p1, r_last_p1;
    logic [LOG2_NFFT-1:0]   r_idx_p1;
    logic [3:0]             r_exp_p1;
    logic [2*N-1:0]         r_re2_p1, r_im2_p1;

    logic                   r_vld_p2, r_first_p2, r_last_p2;
    logic [LOG2_NFFT-1:0]   r_idx_p2;
    logic [3:0]             r_exp_p2;
    logic [2*N:0]           r_sum_p2;

    logic [2*N:0]           r_max;
    logic [LOG2_NFFT-1:0]   r_bin;
    logic [2*N:0]           w_max;
    logic [LOG2_NFFT-1:0]   w_bin;
    logic                   w_elig;

    // Stage 0: bin acceptance and index tagging; an accepted FD_OUT always opens bin 0.
    always_comb begin
        w_fd   = DATA_VALID & FD_OUT;
        w_take = w_fd | (DATA_VALID & (r_state == ACCUM));
        w_idx  = w_fd ? '0 : r_cnt;
        w_last = ~w_fd & (r_cnt == LAST_BIN);
        w_exp  = w_fd ? BLK_EXP : r_exp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_drain   <= 1'b0;
            r_exp     <= '0;
            r_vld_p1  <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            r_vld_p1  <= w_take;
            FRAME_ERR <= w_fd && (r_state == ACCUM);
            case (r_state)
                ACCUM: begin
                    if (DATA_VALID) begin
                        if (r_cnt == LAST_BIN) begin
                            r_state <= FLUSH;
                            r_cnt   <= '0;
                            r_drain <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (!r_drain) r_state <= DONE;
                    else          r_drain <= 1'b0;
                end
                DONE:    r_state <= IDLE;
                default: ;
            endcase
            if (w_fd) begin
                r_state <= ACCUM;
                r_cnt   <= LOG2_NFFT'(1);
                r_exp   <= BLK_EXP;
            end
        end
    end

    // Stage 1: squares; Stage 2: 2N+1-bit sum. Tags ride along with the data.
    always_ff @(posedge clk) begin
        r_re2_p1   <= square(XK_RE);
        r_im2_p1   <= square(XK_IM);
        r_idx_p1   <= w_idx;
        r_first_p1 <= w_fd;
        r_last_p1  <= w_last;
        r_exp_p1   <= w_exp;
        r_sum_p2   <= {1'b0, r_re2_p1} + {1'b0, r_im2_p1};
        r_idx_p2   <= r_idx_p1;
        r_first_p2 <= r_first_p1;
        r_last_p2  <= r_last_p1;
        r_exp_p2   <= r_exp_p1;
    end

    // Stage 3: strict greater-than running max; the first bin of a frame restarts it.
    always_comb begin
        w_elig = eligible(r_idx_p2);
        w_max  = r_max;
        w_bin  = r_bin;
        if (r_first_p2) begin
            w_max = w_elig ? r_sum_p2 : '0;
            w_bin = w_elig ? r_idx_p2 : DEF_BIN;
        end else if (w_elig && (r_sum_p2 > r_max)) begin
            w_max = r_sum_p2;
            w_bin = r_idx_p2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p2   <= 1'b0;
            r_max      <= '0;
            r_bin      <= DEF_BIN;
            PEAK_BIN   <= DEF_BIN;
            PEAK_MAG   <= '0;
            PEAK_EXP   <= '0;
            PEAK_VALID <= 1'b0;
        end else begin
            r_vld_p2   <= r_vld_p1;
            PEAK_VALID <= 1'b0;
            if (r_vld_p2) begin
                r_max <= w_max;
                r_bin <= w_bin;
                if (r_last_p2) begin
                    PEAK_BIN   <= w_bin;
                    PEAK_MAG   <= w_max;
                    PEAK_EXP   <= r_exp_p2;
                    PEAK_VALID <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dft_peak_detector.sv
// Directed bench for dft_peak_detector with a frame-level reference model and per-cycle compare.
module tb_dft_peak_detector;
    localparam int N    = 18;
    localparam int NFFT = 4;
    localparam int LOG2 = 2;
    localparam int DEPTH = 4096;
`ifdef PEAK_DC_SKIP_EN
    localparam int LO = 1;
    localparam int DEF_BIN = 1;
    localparam int T1_BIN = 1;
    localparam int T1_MAG = 8;
`else
    localparam int LO = 0;
    localparam int DEF_BIN = 0;
    localparam int T1_BIN = 0;
    localparam int T1_MAG = 36;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic signed [N-1:0] xr = '0;
    logic signed [N-1:0] xi = '0;
    logic [3:0] bexp = '0;
    logic fd = 1'b0;
    logic dv = 1'b0;
    wire [LOG2-1:0] pbin;
    wire [2*N:0]    pmag;
    wire [3:0]      pexp;
    wire            pv;
    wire            ferr;

    dft_peak_detector #(.N(N), .NFFT(NFFT)) dut (
        .clk(clk), .rst_n(rst_n), .XK_RE(xr), .XK_IM(xi), .BLK_EXP(bexp),
        .FD_OUT(fd), .DATA_VALID(dv), .PEAK_BIN(pbin), .PEAK_MAG(pmag),
        .PEAK_EXP(pexp), .PEAK_VALID(pv), .FRAME_ERR(ferr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit     ex_pv  [0:DEPTH-1];
    bit     ex_fe  [0:DEPTH-1];
    int     ex_bin [0:DEPTH-1];
    longint ex_mag [0:DEPTH-1];
    int     ex_exp [0:DEPTH-1];

    bit     m_in = 1'b0;
    int     m_cnt = 0;
    int     m_exp = 0;
    longint m_re [NFFT];
    longint m_im [NFFT];
    int     last_acc = 0;

    int     h_bin = DEF_BIN;
    longint h_mag = 0;
    int     h_exp = 0;
    int     n_pv = 0;
    int     n_fe = 0;
    int     last_pv_cyc = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Peak of a completed frame straight from the rules: max re^2+im^2 over eligible bins, lowest index on ties.
    task automatic finish_frame(input int k);
        longint best;
        longint mag;
        int bb;
        best = -1;
        bb = LO;
        for (int b = LO; b <= NFFT / 2; b++) begin
            mag = m_re[b] * m_re[b] + m_im[b] * m_im[b];
            if (mag > best) begin
                best = mag;
                bb = b;
            end
        end
        ex_pv[k+3]  = 1'b1;
        ex_bin[k+3] = bb;
        ex_mag[k+3] = best;
        ex_exp[k+3] = m_exp;
    endtask

    task automatic send(input longint re, input longint im, input bit f, input int e);
        int k;
        @(posedge clk);
        #2;
        xr = re[N-1:0];
        xi = im[N-1:0];
        fd = f;
        dv = 1'b1;
        bexp = e[3:0];
        k = cyc;
        if (f) begin
            if (m_in && m_cnt != 0) ex_fe[k+1] = 1'b1;
            m_in = 1'b1;
            m_cnt = 0;
            m_exp = e;
        end
        if (m_in) begin
            m_re[m_cnt] = re;
            m_im[m_cnt] = im;
            m_cnt++;
            last_acc = k;
            if (m_cnt == NFFT) begin
                finish_frame(k);
                m_in = 1'b0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            dv = 1'b0;
            fd = 1'b0;
            xr = '0;
            xi = '0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        dv = 1'b0;
        fd = 1'b0;
        m_in = 1'b0;
        m_cnt = 0;
        for (int i = cyc; i < DEPTH; i++) begin
            ex_pv[i] = 1'b0;
            ex_fe[i] = 1'b0;
        end
    endtask

    task automatic frame1(input int e);
        send(6, 0, 1'b1, e);
        send(-2, 2, 1'b0, e);
        send(-2, 0, 1'b0, e);
        send(-2, -2, 1'b0, e);
    endtask

    task automatic expect_result(input string tag, input int npv0, input int npv_exp,
                                 input int b, input longint m, input int e);
        chk({tag, "_npv"}, n_pv - npv0, npv_exp);
        chk({tag, "_bin"}, pbin, b);
        chk({tag, "_mag"}, pmag, m);
        chk({tag, "_exp"}, pexp, e);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            h_bin = DEF_BIN;
            h_mag = 0;
            h_exp = 0;
        end else if (ex_pv[cyc]) begin
            h_bin = ex_bin[cyc];
            h_mag = ex_mag[cyc];
            h_exp = ex_exp[cyc];
        end
        chk("PEAK_VALID", pv, ex_pv[cyc]);
        chk("FRAME_ERR", ferr, ex_fe[cyc]);
        chk("PEAK_BIN", pbin, h_bin);
        chk("PEAK_MAG", pmag, h_mag);
        chk("PEAK_EXP", pexp, h_exp);
        if (pv === 1'b1) begin
            n_pv++;
            last_pv_cyc = cyc;
        end
        if (ferr === 1'b1) n_fe++;
    end

    initial begin
        int p0;
        int f0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_bin", pbin, DEF_BIN);
        chk("rst_mag", pmag, 0);
        chk("rst_exp", pexp, 0);
        chk("rst_pv", pv, 0);
        chk("rst_fe", ferr, 0);
        rst_n = 1'b1;
        idle(2);

        p0 = n_pv;
        frame1(3);
        idle(6);
        expect_result("t1", p0, 1, T1_BIN, T1_MAG, 3);
        chk("t1_lat", last_pv_cyc - last_acc, 3);

        p0 = n_pv;
        send(0, 0, 1'b1, 5);
        send(3, 0, 1'b0, 5);
        send(-3, 0, 1'b0, 5);
        send(0, 0, 1'b0, 5);
        idle(6);
        expect_result("tie", p0, 1, 1, 9, 5);

        p0 = n_pv;
        send(6, 0, 1'b1, 3);
        idle(2);
        send(-2, 2, 1'b0, 3);
        idle(2);
        send(-2, 0, 1'b0, 3);
        idle(2);
        send(-2, -2, 1'b0, 3);
        idle(6);
        expect_result("gap", p0, 1, T1_BIN, T1_MAG, 3);
        chk("gap_lat", last_pv_cyc - last_acc, 3);

        p0 = n_pv;
        send(0, 0, 1'b1, 7);
        send(-131072, -131072, 1'b0, 7);
        send(0, 0, 1'b0, 7);
        send(0, 0, 1'b0, 7);
        idle(6);
        expect_result("ext", p0, 1, 1, 64'h8_0000_0000, 7);

        p0 = n_pv;
        f0 = n_fe;
        send(6, 0, 1'b1, 2);
        send(-2, 2, 1'b0, 2);
        frame1(3);
        idle(6);
        expect_result("abort", p0, 1, T1_BIN, T1_MAG, 3);
        chk("abort_nfe", n_fe - f0, 1);

        p0 = n_pv;
        frame1(3);
        send(0, 0, 1'b1, 5);
        send(3, 0, 1'b0, 5);
        send(-3, 0, 1'b0, 5);
        send(0, 0, 1'b0, 5);
        idle(6);
        expect_result("b2b", p0, 2, 1, 9, 5);

        p0 = n_pv;
        send(6, 0, 1'b1, 3);
        send(-2, 2, 1'b0, 3);
        do_reset();
        #1;
        chk("mrst_bin", pbin, DEF_BIN);
        chk("mrst_mag", pmag, 0);
        chk("mrst_exp", pexp, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        send(-2, 0, 1'b0, 3);
        send(-2, -2, 1'b0, 3);
        idle(6);
        chk("mrst_npv", n_pv - p0, 0);

        p0 = n_pv;
        send(5, 0, 1'b0, 1);
        send(5, 5, 1'b0, 1);
        send(1, 0, 1'b0, 1);
        send(1, 1, 1'b0, 1);
        idle(6);
        chk("nofd_npv", n_pv - p0, 0);

        p0 = n_pv;
        send(0, 0, 1'b1, 4);
        send(0, 0, 1'b0, 4);
        send(0, 0, 1'b0, 4);
        send(0, 0, 1'b0, 4);
        idle(6);
        expect_result("zero", p0, 1, DEF_BIN, 0, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
